// File: rtl/rom_arbiter_if.sv
// Requester ports A/B plus the ROM bus shared by rom_arbiter.
// The arbiter side uses the slave modport; requesters and the ROM use master.
interface rom_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req;
    logic [ADDR_W-1:0] b_addr;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_dataeno;
    logic [DATA_W-1:0] rom_data;
    logic              busy;

    modport slave (
        input  a_req, a_addr, b_req, b_addr, rom_data,
        output a_ack, a_rdata, b_ack, b_rdata, rom_addr, rom_dataeno, busy
    );

    modport master (
        output a_req, a_addr, b_req, b_addr, rom_data,
        input  a_ack, a_rdata, b_ack, b_rdata, rom_addr, rom_dataeno, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the program ROM.
// Each access: grant, WAIT_CYCLES+1 cycles of ROM drive, capture, one turnaround cycle.
module rom_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset,
    rom_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       PORT_A    = 1'b0;
    localparam logic       PORT_B    = 1'b1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_nxt;
    logic              dataeno_q, dataeno_nxt;
    logic              a_ack_q, a_ack_nxt;
    logic              b_ack_q, b_ack_nxt;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_nxt;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic              gnt, gnt_nxt;
    logic              last, last_nxt;
    logic              pick;

    // On a tie the port that was not served last wins; a lone request simply wins.
    always_comb begin
        if (bus.a_req && bus.b_req) begin
            pick = ~last;
        end else begin
            pick = bus.b_req ? PORT_B : PORT_A;
        end
    end

    always_comb begin
        state_nxt    = state;
        rom_addr_nxt = rom_addr_q;
        dataeno_nxt  = dataeno_q;
        a_ack_nxt    = 1'b0;
        b_ack_nxt    = 1'b0;
        a_rdata_nxt  = a_rdata_q;
        b_rdata_nxt  = b_rdata_q;
        wait_cnt_nxt = wait_cnt;
        gnt_nxt      = gnt;
        last_nxt     = last;
        case (state)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    rom_addr_nxt = (pick == PORT_B) ? bus.b_addr : bus.a_addr;
                    dataeno_nxt  = 1'b1;
                    wait_cnt_nxt = WAIT_INIT;
                    gnt_nxt      = pick;
                    last_nxt     = pick;
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end else begin
                    if (gnt == PORT_B) begin
                        b_rdata_nxt = bus.rom_data;
                        b_ack_nxt   = 1'b1;
                    end else begin
                        a_rdata_nxt = bus.rom_data;
                        a_ack_nxt   = 1'b1;
                    end
                    dataeno_nxt = 1'b0;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                // Turnaround: the ack is visible now and the requester drops its req.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                dataeno_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            rom_addr_q <= '0;
            dataeno_q  <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            wait_cnt   <= 4'd0;
            gnt        <= PORT_A;
            last       <= PORT_B;
        end else begin
            state      <= state_nxt;
            rom_addr_q <= rom_addr_nxt;
            dataeno_q  <= dataeno_nxt;
            a_ack_q    <= a_ack_nxt;
            b_ack_q    <= b_ack_nxt;
            a_rdata_q  <= a_rdata_nxt;
            b_rdata_q  <= b_rdata_nxt;
            wait_cnt   <= wait_cnt_nxt;
            gnt        <= gnt_nxt;
            last       <= last_nxt;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.rom_dataeno = dataeno_q;
    assign bus.a_ack       = a_ack_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.busy        = (state != IDLE);
endmodule
